// File: rtl/core_bus_scheduler_pkg.sv
// core_bus_pkg: opcodes, FSM states, address field bounds and error word for the core bus scheduler
package core_bus_pkg;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_STREAM_SEL = 8'h03;
  localparam int CORE_ID_HI = 23;
  localparam int CORE_ID_LO = 16;
  localparam int LOCAL_HI = 15;
  localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
endpackage

// File: rtl/core_bus_scheduler_if.sv
// core_bus_scheduler_if: command, response and per-core bus signals of the scheduler
interface core_bus_scheduler_if #(parameter int NUM_CORES = 4);
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic [7:0] instruction_i;
  logic [23:0] address_i;
  logic [31:0] value_i;
  logic [31:0] result_o;
  logic result_valid_o;
  logic error_o;
  logic [NUM_CORES-1:0] core_req_o;
  logic [7:0] core_instruction_o;
  logic [15:0] core_address_o;
  logic [31:0] core_value_o;
  logic [NUM_CORES-1:0] core_ack_i;
  logic [NUM_CORES*32-1:0] core_result_i;
  logic [NUM_CORES*32-1:0] core_stream_i;
  logic [31:0] stream_o;
  modport slave (
    input cmd_valid_i, instruction_i, address_i, value_i, core_ack_i, core_result_i, core_stream_i,
    output cmd_ready_o, result_o, result_valid_o, error_o, core_req_o, core_instruction_o,
    core_address_o, core_value_o, stream_o
  );
  modport master (
    output cmd_valid_i, instruction_i, address_i, value_i, core_ack_i, core_result_i, core_stream_i,
    input cmd_ready_o, result_o, result_valid_o, error_o, core_req_o, core_instruction_o,
    core_address_o, core_value_o, stream_o
  );
endinterface

// File: rtl/core_bus_scheduler.sv
// core_bus_scheduler: routes one command at a time to an addressed core and returns its result
module core_bus_scheduler
  import core_bus_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst_i,
  core_bus_scheduler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] NC = 8'(NUM_CORES);
  state_t state, state_n;
  logic [NUM_CORES-1:0] req, hot;
  logic [CW-1:0] cnt;
  logic [3:0] sel;
  logic [31:0] resp, ack_word, stream_d;
  logic [7:0] id;
  logic err_pend, accept, hit, expire, is_nop, is_sel, core_op;
  assign id = bus.address_i[CORE_ID_HI:CORE_ID_LO];
  assign bus.cmd_ready_o = state == IDLE;
  assign bus.core_req_o = req;
  assign accept = bus.cmd_valid_i && bus.cmd_ready_o;
  assign is_nop = bus.instruction_i == OP_NOP;
  assign is_sel = bus.instruction_i == OP_STREAM_SEL;
  assign core_op = !is_nop && !is_sel && id < NC;
  assign hot = NUM_CORES'(1) << id;
  // req is one-hot on the addressed core, so masking acks with it ignores every other core
  assign hit = |(bus.core_ack_i & req);
  assign expire = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    ack_word = '0;
    stream_d = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      ack_word = ack_word | (req[k] ? bus.core_result_i[32*k +: 32] : 32'h0);
      stream_d = (sel == 4'(k)) ? bus.core_stream_i[32*k +: 32] : stream_d;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (accept ? (core_op ? ISSUE : RESPOND) : IDLE)
            : state == ISSUE ? ((hit || expire) ? RESPOND : ISSUE)
            : IDLE;
  end
  always_ff @(posedge clk_i) begin
    state <= rst_i ? IDLE : state_n;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req <= '0;
      cnt <= '0;
      sel <= '0;
      resp <= '0;
      err_pend <= 1'b0;
      bus.result_o <= '0;
      bus.result_valid_o <= 1'b0;
      bus.error_o <= 1'b0;
      bus.core_instruction_o <= '0;
      bus.core_address_o <= '0;
      bus.core_value_o <= '0;
      bus.stream_o <= '0;
    end else begin
      bus.result_valid_o <= state == RESPOND;
      bus.error_o <= state == RESPOND && err_pend;
      bus.stream_o <= stream_d;
      if (state == RESPOND) bus.result_o <= resp;
      if (accept) begin
        bus.core_instruction_o <= bus.instruction_i;
        bus.core_address_o <= bus.address_i[LOCAL_HI:0];
        bus.core_value_o <= bus.value_i;
        req <= core_op ? hot : '0;
        cnt <= '0;
        err_pend <= !is_nop && !is_sel && !core_op;
        resp <= is_sel ? bus.value_i : (is_nop ? 32'h0 : ERR_WORD);
        if (is_sel) sel <= bus.value_i[3:0];
      end
      // an ack on the expiry edge takes priority over the timeout
      if (state == ISSUE) begin
        if (hit) begin
          resp <= ack_word;
          req <= '0;
        end else if (expire) begin
          resp <= ERR_WORD;
          err_pend <= 1'b1;
          req <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_core_bus_scheduler.sv
// tb_core_bus_scheduler: directed and randomized commands checked against a transaction-level model
module tb_core_bus_scheduler;
  import core_bus_pkg::*;
  localparam int NC = 4;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [3:0] sel_m = 4'h0;
  core_bus_scheduler_if #(.NUM_CORES(NC)) bus();
  core_bus_scheduler #(.NUM_CORES(NC), .TIMEOUT_CYCLES(T)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cores(input int id, input logic [31:0] res, input logic [NC-1:0] ack);
    for (int k = 0; k < NC; k++) begin
      bus.core_result_i[32*k +: 32] = (k == id) ? res : $urandom;
      bus.core_stream_i[32*k +: 32] = $urandom;
    end
    bus.core_ack_i = ack;
  endtask

  // d = cycle (counted from the first request cycle) in which the addressed core acks
  task automatic do_cmd(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] val,
                        input int d, input logic [31:0] res, input logic [NC-1:0] extra);
    int id, fin, lat, seen;
    logic issue, ee;
    logic [NC-1:0] hot, ack;
    logic [31:0] er;
    id = int'(addr[23:16]);
    issue = op != OP_NOP && op != OP_STREAM_SEL && id < NC;
    hot = '0;
    if (issue) hot[id] = 1'b1;
    fin = (d < T) ? d + 1 : T;
    lat = issue ? fin + 1 : 1;
    er = (op == OP_NOP) ? 32'h0 : (op == OP_STREAM_SEL) ? val : (issue && d < T) ? res : 32'hFFFF_FFFF;
    ee = op != OP_NOP && op != OP_STREAM_SEL && !(issue && d < T);
    seen = -1;
    @(negedge clk);
    chk("cmd_ready", bus.cmd_ready_o, 1);
    bus.cmd_valid_i = 1'b1;
    bus.instruction_i = op;
    bus.address_i = addr;
    bus.value_i = val;
    drive_cores(id, res, '0);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.instruction_i = 8'($urandom);
    bus.address_i = 24'($urandom);
    bus.value_i = $urandom;
    chk("cmd_ready_busy", bus.cmd_ready_o, 0);
    if (issue) begin
      chk("core_instruction", bus.core_instruction_o, op);
      chk("core_address", bus.core_address_o, addr[15:0]);
      chk("core_value", bus.core_value_o, val);
    end
    for (int c = 0; c <= lat + 2 && seen < 0; c++) begin
      chk("core_req", bus.core_req_o, (issue && c < fin) ? hot : '0);
      if (bus.result_valid_o) begin
        seen = c;
        chk("result", bus.result_o, er);
        chk("error", bus.error_o, ee);
      end else begin
        chk("error_quiet", bus.error_o, 0);
        ack = NC'($urandom) & ~hot;
        if (issue && c == d) ack = ack | hot | extra;
        drive_cores(id, res, ack);
        @(negedge clk);
      end
    end
    chk("latency", seen, lat);
    drive_cores(id, res, '0);
    @(negedge clk);
    chk("valid_pulse", bus.result_valid_o, 0);
    chk("error_pulse", bus.error_o, 0);
    chk("result_hold", bus.result_o, er);
    if (op == OP_STREAM_SEL) sel_m = val[3:0];
  endtask

  task automatic check_stream(input logic [31:0] first, input int n);
    logic [31:0] w, exp;
    for (int i = 0; i < n; i++) begin
      exp = 32'h0;
      for (int k = 0; k < NC; k++) begin
        w = (i == 0 && k == int'(sel_m)) ? first : $urandom;
        bus.core_stream_i[32*k +: 32] = w;
        if (k == int'(sel_m)) exp = w;
      end
      @(negedge clk);
      chk("stream", bus.stream_o, exp);
    end
  endtask

  initial begin
    logic [7:0] op;
    logic [31:0] v;
    bus.cmd_valid_i = 1'b0;
    bus.instruction_i = '0;
    bus.address_i = '0;
    bus.value_i = '0;
    bus.core_ack_i = '0;
    bus.core_result_i = '0;
    bus.core_stream_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", bus.core_req_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_valid", bus.result_valid_o, 0);
    chk("rst_error", bus.error_o, 0);
    chk("rst_core_instruction", bus.core_instruction_o, 0);
    chk("rst_core_address", bus.core_address_o, 0);
    chk("rst_core_value", bus.core_value_o, 0);
    chk("rst_stream", bus.stream_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.cmd_ready_o, 1);
    do_cmd(8'h01, 24'h01_0040, $urandom, 2, 32'h1234_5678, '0);
    do_cmd(8'h01, 24'h02_0010, $urandom, 99, $urandom, '0);
    do_cmd(8'h05, 24'h07_0000, $urandom, 0, $urandom, '0);
    do_cmd(OP_STREAM_SEL, 24'h00_0000, 32'h2, 0, 0, '0);
    check_stream(32'hCAFE_0002, 4);
    do_cmd(8'h02, 24'h00_1234, $urandom, 1, 32'hA5A5_0000, 4'b1000);
    do_cmd(8'h02, 24'h03_0008, $urandom, T - 1, 32'h0BAD_F00D, '0);
    do_cmd(8'h02, 24'h03_0008, $urandom, T, 32'h0BAD_F00D, '0);
    do_cmd(OP_NOP, 24'h01_0000, $urandom, 0, $urandom, '0);
    do_cmd(OP_STREAM_SEL, 24'h00_0000, 32'h5, 0, 0, '0);
    check_stream($urandom, 3);
    // reset while core 2 is being requested
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.instruction_i = 8'h01;
    bus.address_i = 24'h02_0000;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_issue_req", bus.core_req_o, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_issue_req", bus.core_req_o, 0);
    chk("rst_issue_valid", bus.result_valid_o, 0);
    rst = 1'b0;
    sel_m = 4'h0;
    @(negedge clk);
    chk("rst_issue_ready", bus.cmd_ready_o, 1);
    for (int i = 0; i < T + 2; i++) begin
      @(negedge clk);
      chk("rst_issue_no_valid", bus.result_valid_o, 0);
    end
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 5);
      op = (r == 0) ? OP_NOP : (r == 1) ? OP_STREAM_SEL : 8'($urandom_range(1, 255));
      if (op == OP_STREAM_SEL && r != 1) op = 8'h04;
      v = (r == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      do_cmd(op, {8'($urandom_range(0, 6)), 16'($urandom)}, v, $urandom_range(0, 11), $urandom, 4'($urandom));
      if (r == 1) check_stream($urandom, 3);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
